// File: rtl/pipeline_stall_controller_if.sv
// Control bundle between the RV32 pipeline and pipeline_stall_controller.
// master = controller side (drives stage controls), slave = pipeline side.
interface pipeline_stall_controller_if;
  logic LU_HAZ_SIG;
  logic BRANCH_TAKEN;
  logic D_MEM_BUSY;
  logic I_MEM_BUSY;
  logic PC_HOLD;
  logic IF_ID_HOLD;
  logic IF_ID_FLUSH;
  logic ID_EX_HOLD;
  logic ID_EX_BUBBLE;
  logic EX_MEM_HOLD;
  logic MEM_WB_BUBBLE;
  logic TIMEOUT_ERR;

  modport master (
    input  LU_HAZ_SIG, BRANCH_TAKEN, D_MEM_BUSY, I_MEM_BUSY,
    output PC_HOLD, IF_ID_HOLD, IF_ID_FLUSH, ID_EX_HOLD, ID_EX_BUBBLE,
           EX_MEM_HOLD, MEM_WB_BUBBLE, TIMEOUT_ERR
  );

  modport slave (
    output LU_HAZ_SIG, BRANCH_TAKEN, D_MEM_BUSY, I_MEM_BUSY,
    input  PC_HOLD, IF_ID_HOLD, IF_ID_FLUSH, ID_EX_HOLD, ID_EX_BUBBLE,
           EX_MEM_HOLD, MEM_WB_BUBBLE, TIMEOUT_ERR
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Per-stage hold/flush/bubble generation for the 5-stage RV32 pipeline.
// Define STALL_PERF_CNT_EN to add the LU/MEM/FLUSH performance counters.
module pipeline_stall_controller #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic CLK,
  input  logic RESET,
  pipeline_stall_controller_if.master ctrl_if
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] LU_STALL_COUNT,
  output logic [31:0] MEM_STALL_COUNT,
  output logic [31:0] FLUSH_COUNT
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(MEM_TIMEOUT);

  state_t                r_state;
  state_t                w_next;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  w_cnt_next;
  logic                  r_timeout;

  logic w_lu_mask;
  logic w_lu_take;
  logic w_br_take;
  logic w_pc_hold;
  logic w_if_id_hold;
  logic w_if_id_flush;
  logic w_id_ex_hold;
  logic w_id_ex_bubble;
  logic w_ex_mem_hold;
  logic w_mem_wb_bubble;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= RUN;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (ctrl_if.D_MEM_BUSY && (w_cnt_next >= TIMEOUT_VAL))
        r_timeout <= 1'b1;
    end
  end

  // MEM_WAIT with busy released falls through to the RUN rules in the same cycle.
  always_comb begin
    w_next          = RUN;
    w_cnt_next      = '0;
    w_lu_take       = 1'b0;
    w_br_take       = 1'b0;
    w_pc_hold       = 1'b0;
    w_if_id_hold    = 1'b0;
    w_if_id_flush   = 1'b0;
    w_id_ex_hold    = 1'b0;
    w_id_ex_bubble  = 1'b0;
    w_ex_mem_hold   = 1'b0;
    w_mem_wb_bubble = 1'b0;
    w_lu_mask       = (r_state == LU_STALL);

    if (ctrl_if.D_MEM_BUSY) begin
      w_next          = MEM_WAIT;
      w_pc_hold       = 1'b1;
      w_if_id_hold    = 1'b1;
      w_id_ex_hold    = 1'b1;
      w_ex_mem_hold   = 1'b1;
      w_mem_wb_bubble = 1'b1;
      case (r_state)
        MEM_WAIT: w_cnt_next = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
        default:  w_cnt_next = CNT_WIDTH'(1);
      endcase
    end else if (ctrl_if.BRANCH_TAKEN) begin
      w_br_take      = 1'b1;
      w_if_id_flush  = 1'b1;
      w_id_ex_bubble = 1'b1;
    end else if (ctrl_if.LU_HAZ_SIG && !w_lu_mask) begin
      // I_MEM_BUSY needs no extra term here: the load-use stall already holds PC.
      w_next         = LU_STALL;
      w_lu_take      = 1'b1;
      w_pc_hold      = 1'b1;
      w_if_id_hold   = 1'b1;
      w_id_ex_bubble = 1'b1;
    end else if (ctrl_if.I_MEM_BUSY) begin
      w_pc_hold     = 1'b1;
      w_if_id_flush = 1'b1;
    end
  end

  assign ctrl_if.PC_HOLD       = w_pc_hold       & ~RESET;
  assign ctrl_if.IF_ID_HOLD    = w_if_id_hold    & ~RESET;
  assign ctrl_if.IF_ID_FLUSH   = w_if_id_flush   & ~RESET;
  assign ctrl_if.ID_EX_HOLD    = w_id_ex_hold    & ~RESET;
  assign ctrl_if.ID_EX_BUBBLE  = w_id_ex_bubble  & ~RESET;
  assign ctrl_if.EX_MEM_HOLD   = w_ex_mem_hold   & ~RESET;
  assign ctrl_if.MEM_WB_BUBBLE = w_mem_wb_bubble & ~RESET;
  assign ctrl_if.TIMEOUT_ERR   = r_timeout;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] r_lu_stall_cnt;
  logic [31:0] r_mem_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_lu_stall_cnt  <= '0;
      r_mem_stall_cnt <= '0;
      r_flush_cnt     <= '0;
    end else begin
      if (w_lu_take)          r_lu_stall_cnt  <= r_lu_stall_cnt + 32'd1;
      if (ctrl_if.D_MEM_BUSY) r_mem_stall_cnt <= r_mem_stall_cnt + 32'd1;
      if (w_br_take)          r_flush_cnt     <= r_flush_cnt + 32'd1;
    end
  end

  assign LU_STALL_COUNT  = r_lu_stall_cnt;
  assign MEM_STALL_COUNT = r_mem_stall_cnt;
  assign FLUSH_COUNT     = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: vector table, corner sequences, random vs model.
// Output vector order: PC_HOLD IF_ID_HOLD IF_ID_FLUSH ID_EX_HOLD ID_EX_BUBBLE EX_MEM_HOLD MEM_WB_BUBBLE TIMEOUT_ERR.
module tb_pipeline_stall_controller;
  localparam int unsigned TO = 4;

  logic CLK;
  logic RESET;
  int   checks;
  int   failures;

  pipeline_stall_controller_if ifc ();

  pipeline_stall_controller #(
    .MEM_TIMEOUT(TO),
    .CNT_WIDTH  (8)
  ) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .ctrl_if(ifc)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [3:0] in;   // {LU_HAZ_SIG, BRANCH_TAKEN, D_MEM_BUSY, I_MEM_BUSY}
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[15];

  function automatic logic [7:0] outs();
    return {ifc.PC_HOLD, ifc.IF_ID_HOLD, ifc.IF_ID_FLUSH, ifc.ID_EX_HOLD,
            ifc.ID_EX_BUBBLE, ifc.EX_MEM_HOLD, ifc.MEM_WB_BUBBLE, ifc.TIMEOUT_ERR};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] in);
    {ifc.LU_HAZ_SIG, ifc.BRANCH_TAKEN, ifc.D_MEM_BUSY, ifc.I_MEM_BUSY} = in;
  endtask

  // Entered at posedge+1: drive, sample mid-cycle, advance past the next edge.
  task automatic cyc(input logic [3:0] in, output logic [7:0] act);
    drive(in);
    #4;
    act = outs();
    @(posedge CLK);
    #1;
  endtask

  // Async reset pulse between edges; outputs must read zero while it is asserted.
  task automatic do_reset(input string name, input logic [3:0] in);
    drive(in);
    RESET = 1'b1;
    #2;
    check(name, outs(), 8'b0);
    RESET = 1'b0;
    drive(4'b0000);
    @(posedge CLK);
    #1;
  endtask

  // Reference model: masked = previous cycle issued a load-use bubble,
  // run = consecutive D busy cycles so far, err = sticky timeout.
  bit m_masked;
  int m_run;
  bit m_err;

  function automatic logic [7:0] model_out(input logic [3:0] in);
    logic lu, br, d, i;
    logic [6:0] c;
    {lu, br, d, i} = in;
    if (d)                    c = 7'b1101011;
    else if (br)              c = 7'b0010100;
    else if (lu && !m_masked) c = 7'b1100100;
    else if (i)               c = 7'b1010000;
    else                      c = 7'b0000000;
    return {c, m_err};
  endfunction

  task automatic model_step(input logic [3:0] in);
    logic lu, br, d, i;
    {lu, br, d, i} = in;
    m_masked = !d && !br && lu && !m_masked;
    if (d) begin
      if (m_run < 255) m_run++;
      if (m_run >= TO) m_err = 1'b1;
    end else begin
      m_run = 0;
    end
  endtask

  task automatic model_reset();
    m_masked = 1'b0;
    m_run    = 0;
    m_err    = 1'b0;
  endtask

  logic [7:0] act;
  logic [3:0] rin;

  initial begin
    checks   = 0;
    failures = 0;
    RESET    = 1'b1;
    drive(4'b0000);

    tbl[0]  = '{4'b0000, 8'b00000000};
    tbl[1]  = '{4'b1000, 8'b11001000};  // load-use bubble
    tbl[2]  = '{4'b1000, 8'b00000000};  // masked second hazard
    tbl[3]  = '{4'b1100, 8'b00101000};  // branch beats hazard
    tbl[4]  = '{4'b0001, 8'b10100000};  // I busy alone
    tbl[5]  = '{4'b1001, 8'b11001000};  // hazard + I busy
    tbl[6]  = '{4'b0001, 8'b10100000};  // LU_STALL, I busy
    tbl[7]  = '{4'b0110, 8'b11010110};  // D busy over branch
    tbl[8]  = '{4'b0110, 8'b11010110};
    tbl[9]  = '{4'b0010, 8'b11010110};
    tbl[10] = '{4'b0100, 8'b00101000};  // busy drops, branch applies
    tbl[11] = '{4'b1000, 8'b11001000};
    tbl[12] = '{4'b1010, 8'b11010110};  // D busy in LU_STALL
    tbl[13] = '{4'b1000, 8'b11001000};  // MEM_WAIT exit takes hazard
    tbl[14] = '{4'b1000, 8'b00000000};

    @(posedge CLK);
    #1;
    do_reset("reset_initial", 4'b1110);
    cyc(4'b0000, act);
    check("idle_after_reset", act, 8'b0);

    for (int unsigned k = 0; k < 15; k++) begin
      cyc(tbl[k].in, act);
      check($sformatf("tbl[%0d]", k), act, tbl[k].exp);
    end

    // Timeout: busy held 6 cycles, flag visible after the 4th busy edge.
    do_reset("reset_pre_timeout", 4'b0000);
    for (int unsigned k = 1; k <= 6; k++) begin
      cyc(4'b0010, act);
      check($sformatf("timeout_busy%0d", k), act, {7'b1101011, (k > TO)});
    end
    cyc(4'b0000, act);
    check("timeout_sticky1", act, 8'b00000001);
    cyc(4'b1000, act);
    check("timeout_sticky_lu", act, 8'b11001001);
    do_reset("reset_midstream", 4'b1101);
    cyc(4'b0000, act);
    check("timeout_cleared", act, 8'b0);

    // Reset during MEM_WAIT restarts the wait count.
    cyc(4'b0010, act);
    cyc(4'b0010, act);
    cyc(4'b0010, act);
    check("memwait_pre_reset", act, 8'b11010110);
    do_reset("reset_memwait", 4'b0010);
    for (int unsigned k = 1; k <= 5; k++) begin
      cyc(4'b0010, act);
      check($sformatf("memwait_after_reset%0d", k), act, {7'b1101011, (k > TO)});
    end

    // Random stimulus against the model.
    do_reset("reset_random", 4'b0000);
    model_reset();
    for (int unsigned n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("reset_random_mid", 4'($urandom_range(0, 15)));
        model_reset();
      end
      rin[3] = ($urandom_range(0, 9) < 4);
      rin[2] = ($urandom_range(0, 9) < 2);
      rin[1] = ($urandom_range(0, 9) < 3);
      rin[0] = ($urandom_range(0, 9) < 3);
      cyc(rin, act);
      check($sformatf("random[%0d] in=%b", n, rin), act, model_out(rin));
      model_step(rin);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
